ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) and 0xF4 (enable).
- It is the opposite direction of the existing keyboard receive path. It shares the PS2_CLK and PS2_DAT open-drain lines, and the top level owns the tristates.
- It runs the inhibit / request-to-send sequence, shifts out data with odd parity on device-generated clocks, and checks the device ACK.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line conditioning.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_WAIT_CLK,
      S_SHIFT,
      S_WAIT_IDLE,
      S_DONE
   } ps2_tx_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_NOSTART = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_NACK    = 2'b11;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] RESP_ACK    = 8'hFA;

   // Parity bit that makes the nine transmitted bits contain an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for one open-drain PS/2 pin.
// The filtered level changes only after FILTER_LEN consecutive identical
// synchronised samples; fall pulses for one cycle on an accepted 1 -> 0 change.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic level,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count how long the synchronised pin has disagreed with the accepted level.
   always_comb begin
      sync1_d = pin_in;
      sync2_d = sync1_q;
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            fall_d  = level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Idle PS/2 lines are pulled high, so everything restarts in the high state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift the byte
// out with odd parity on device clocks, then check the device ACK bit.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic [1:0] err_code
);

   import ps2_pkg::*;

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [1:0]       result_q, result_d;
   logic             tx_ready_q, tx_ready_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_ok_q, ack_ok_d;
   logic [1:0]       err_code_q, err_code_d;

   logic clk_level, clk_fall, dat_level, tmo_hit;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk    (CLOCK_50),
      .reset  (reset),
      .pin_in (ps2_clk_in),
      .level  (clk_level),
      .fall   (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
      .clk    (CLOCK_50),
      .reset  (reset),
      .pin_in (ps2_dat_in),
      .level  (dat_level),
      .fall   ()
   );

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   // Next-state logic; every output is registered from the state being entered.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      parity_d  = parity_q;
      bit_idx_d = bit_idx_q;
      inh_cnt_d = '0;
      tmo_cnt_d = '0;
      result_d  = result_q;
      dat_oe_d  = dat_oe_q;
      case (state_q)
         S_IDLE: begin
            dat_oe_d  = 1'b0;
            bit_idx_d = '0;
            if (tx_valid && tx_ready_q) begin
               data_d   = tx_data;
               parity_d = odd_parity(tx_data);
               result_d = ERR_NONE;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               dat_oe_d = 1'b1;
               state_d  = S_RTS;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         S_RTS: begin
            state_d = S_WAIT_CLK;
         end
         S_WAIT_CLK, S_SHIFT: begin
            if (clk_fall) begin
               if (bit_idx_q < 4'd8) begin
                  dat_oe_d = ~data_q[bit_idx_q[2:0]];
               end else if (bit_idx_q == 4'd8) begin
                  dat_oe_d = ~parity_q;
               end else begin
                  dat_oe_d = 1'b0;
               end
               if (bit_idx_q == 4'd10) begin
                  result_d = dat_level ? ERR_NACK : ERR_NONE;
                  state_d  = S_WAIT_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  state_d   = S_SHIFT;
               end
            end else if (tmo_hit) begin
               dat_oe_d = 1'b0;
               result_d = (state_q == S_WAIT_CLK) ? ERR_NOSTART : ERR_TIMEOUT;
               state_d  = S_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            dat_oe_d = 1'b0;
            if (clk_level && dat_level) begin
               state_d = S_DONE;
            end else if (clk_fall) begin
               tmo_cnt_d = '0;
            end else if (tmo_hit) begin
               result_d = ERR_TIMEOUT;
               state_d  = S_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
      tx_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
      clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_RTS);
      done_d     = (state_d == S_DONE);
      ack_ok_d   = done_d && (result_d == ERR_NONE);
      err_code_d = done_d ? result_d : ERR_NONE;
   end

   // State and output registers; reset releases both lines immediately.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         parity_q   <= 1'b0;
         bit_idx_q  <= '0;
         inh_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         result_q   <= ERR_NONE;
         tx_ready_q <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         parity_q   <= parity_d;
         bit_idx_q  <= bit_idx_d;
         inh_cnt_q  <= inh_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         result_q   <= result_d;
         tx_ready_q <= tx_ready_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_ok_q   <= ack_ok_d;
         err_code_q <= err_code_d;
      end
   end

   assign tx_ready   = tx_ready_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ack_ok     = ack_ok_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model answers the host on the open-drain
// lines, and expected frames/results queued at request time are compared
// when the transmitter reports done.
module tb_ps2_host_tx;

   import ps2_pkg::*;

   localparam int INH  = 50;
   localparam int FLT  = 4;
   localparam int TMO  = 2000;
   localparam int HALF = 40;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       dev_clk  = 1'b1;
   logic       dev_dat  = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;
   logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok;
   logic [1:0] err_code;

   typedef struct {
      logic [9:0] frame;
      logic       check_frame;
      logic       ack;
      logic [1:0] err;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [9:0] got_frame   = '0;
   int         done_cnt    = 0;
   logic       done_prev   = 1'b0;
   logic       done_wide   = 1'b0;
   logic       snap_ack    = 1'b0;
   logic [1:0] snap_err    = 2'b00;
   logic [1:0] snap_oe     = 2'b00;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #5 CLOCK_50 = ~CLOCK_50;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .FILTER_LEN     (FLT),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .err_code   (err_code)
   );

   // Capture the result outputs whenever done pulses and flag pulses longer than one cycle.
   always @(negedge CLOCK_50) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         snap_ack <= ack_ok;
         snap_err <= err_code;
         snap_oe  <= {ps2_clk_oe, ps2_dat_oe};
      end
      if (done && done_prev) done_wide <= 1'b1;
      done_prev <= done;
   end

   // Hard stop in case the sequence gets stuck somewhere unbounded.
   initial begin
      repeat (60000) @(posedge CLOCK_50);
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic oddParity(input logic [7:0] d);
      return ($countones(d) % 2) == 0;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Request a transfer and queue what the device and the result outputs should show.
   task automatic applyStimulus(input logic [7:0] data, input exp_t e, input bit push);
      int n = 0;
      while (!tx_ready && n < 200) begin
         waitCycles(1);
         n++;
      end
      checkOutput("ready_before_tx", tx_ready, 1);
      tx_data  = data;
      tx_valid = 1'b1;
      waitCycles(1);
      tx_valid = 1'b0;
      if (push) exp_q.push_back(e);
   endtask

   // Measure the inhibit window and the request-to-send cycle.
   task automatic measureRequest(input bit poke);
      int n = 0;
      checkOutput("busy_during_tx", busy, 1);
      while (ps2_clk_oe && !ps2_dat_oe && n < INH + 20) begin
         if (poke && n < 5) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
         end else begin
            tx_valid = 1'b0;
         end
         waitCycles(1);
         n++;
      end
      tx_valid = 1'b0;
      checkOutput("inhibit_len", n, INH);
      checkOutput("rts_both_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
      waitCycles(1);
      checkOutput("clk_released", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
   endtask

   // Device model: clocks the frame, samples on rising edges, then ACKs or NACKs.
   task automatic deviceClock(input bit nack, input bit glitch, input int abort_at);
      got_frame = '0;
      checkOutput("rts_data_low", ps2_dat_in, 0);
      waitCycles(HALF);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         waitCycles(HALF);
         got_frame[i] = ps2_dat_in;
         dev_clk = 1'b1;
         if (i == abort_at) return;
         if (glitch && i == 4) begin
            waitCycles(15);
            dev_clk = 1'b0;
            waitCycles(2);
            dev_clk = 1'b1;
            waitCycles(HALF - 17);
         end else begin
            waitCycles(HALF);
         end
      end
      if (!nack) dev_dat = 1'b0;
      waitCycles(HALF / 2);
      dev_clk = 1'b0;
      waitCycles(HALF);
      dev_clk = 1'b1;
      waitCycles(HALF / 2);
      dev_dat = 1'b1;
   endtask

   task automatic waitDone(input int start);
      int n = 0;
      while (done_cnt == start && n < TMO + 500) begin
         waitCycles(1);
         n++;
      end
      checkOutput("done_seen", done_cnt, start + 1);
   endtask

   // Pop the oldest expectation and compare it with what was captured at done.
   task automatic checkResult();
      exp_t e;
      checkOutput("scoreboard_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.check_frame) checkOutput("frame_bits", got_frame, e.frame);
         checkOutput("ack_ok", snap_ack, e.ack);
         checkOutput("err_code", snap_err, e.err);
         checkOutput("oe_at_done", snap_oe, 2'b00);
      end
      checkOutput("idle_after_done", {busy, tx_ready}, 2'b01);
      checkOutput("done_single_cycle", done_wide, 0);
   endtask

   task automatic runFrame(input logic [7:0] data, input bit nack, input bit glitch,
                           input bit poke, input int abort_at, input bit reset_abort);
      exp_t e;
      int   start;
      e.frame       = {1'b1, oddParity(data), data};
      e.check_frame = (abort_at < 0);
      e.ack         = (abort_at < 0) && !nack;
      e.err         = (abort_at >= 0) ? ERR_TIMEOUT : (nack ? ERR_NACK : ERR_NONE);
      applyStimulus(data, e, !reset_abort);
      measureRequest(poke);
      start = done_cnt;
      deviceClock(nack, glitch, abort_at);
      if (reset_abort) begin
         checkOutput("dat_driven_pre_reset", ps2_dat_oe, 1);
         reset = 1'b1;
         waitCycles(1);
         checkOutput("reset_oe_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
         checkOutput("reset_busy", busy, 0);
         reset = 1'b0;
         waitCycles(1);
         checkOutput("ready_after_reset", tx_ready, 1);
         waitCycles(30);
         checkOutput("reset_no_done", done_cnt, start);
      end else begin
         waitDone(start);
         checkResult();
      end
   endtask

   task automatic noClockFrame(input logic [7:0] data);
      exp_t e;
      int   n = 0;
      int   start;
      e.frame       = '0;
      e.check_frame = 1'b0;
      e.ack         = 1'b0;
      e.err         = ERR_NOSTART;
      applyStimulus(data, e, 1'b1);
      measureRequest(1'b0);
      start = done_cnt;
      while (!done && n < TMO + 100) begin
         waitCycles(1);
         n++;
      end
      checkOutput("nostart_delay", n, TMO);
      checkOutput("nostart_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      waitDone(start);
      checkResult();
   endtask

   initial begin
      $display("[TB] ps2_host_tx bench starting");
      waitCycles(3);
      checkOutput("reset_outputs", {tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, err_code}, 8'h00);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("ready_after_reset_release", tx_ready, 1);

      runFrame(CMD_SET_LED, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      checkOutput("set_led_bits", got_frame, 10'b11_1110_1101);
      runFrame(CMD_RESET, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      runFrame(8'h01, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      runFrame(8'h00, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      runFrame(CMD_ENABLE, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      noClockFrame(CMD_RESET);
      runFrame(8'h5A, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      runFrame(8'hA3, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      runFrame(CMD_SET_LED, 1'b0, 1'b0, 1'b0, 4, 1'b1);
      runFrame(CMD_ENABLE, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
